// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, memory-port and response signals shared by the data-memory arbiter.
// The slave side is the arbiter; the master side is requesters plus memory.
interface dmem_arbiter_if #(
    parameter int data_width = 32,
    parameter int addr_width = 15,
    parameter int NREQ       = 4
);
    logic [NREQ-1:0]            i_REQ_VALID;
    logic [NREQ-1:0]            i_REQ_WE;
    logic [NREQ*addr_width-1:0] i_REQ_ADDR;
    logic [NREQ*data_width-1:0] i_REQ_WDATA;
    logic [NREQ-1:0]            o_REQ_READY;
    logic                       o_MEM_EN;
    logic                       o_MEM_WE;
    logic [addr_width-1:0]      o_MEM_ADDR;
    logic [data_width-1:0]      o_MEM_WDATA;
    logic [data_width-1:0]      i_MEM_RDATA;
    logic [NREQ-1:0]            o_RSP_VALID;
    logic [data_width-1:0]      o_RSP_RDATA;

    modport slave (
        input  i_REQ_VALID, i_REQ_WE, i_REQ_ADDR, i_REQ_WDATA, i_MEM_RDATA,
        output o_REQ_READY, o_MEM_EN, o_MEM_WE, o_MEM_ADDR, o_MEM_WDATA,
        output o_RSP_VALID, o_RSP_RDATA
    );

    modport master (
        output i_REQ_VALID, i_REQ_WE, i_REQ_ADDR, i_REQ_WDATA, i_MEM_RDATA,
        input  o_REQ_READY, o_MEM_EN, o_MEM_WE, o_MEM_ADDR, o_MEM_WDATA,
        input  o_RSP_VALID, o_RSP_RDATA
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Four-way round-robin arbiter onto a single data-memory port, with one-cycle
// read responses routed back to the requester that issued them.
module dmem_arbiter #(
    parameter int data_width = 32,
    parameter int addr_width = 15,
    parameter int NREQ       = 4
) (
    input  logic          i_CLK,
    input  logic          i_RSTN,
    dmem_arbiter_if.slave bus
);
    logic [addr_width-1:0] req_addr  [NREQ];
    logic [data_width-1:0] req_wdata [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_split
            assign req_addr[gi]  = bus.i_REQ_ADDR[gi*addr_width +: addr_width];
            assign req_wdata[gi] = bus.i_REQ_WDATA[gi*data_width +: data_width];
        end
    endgenerate

    logic [1:0]      p_q, p_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [1:0]      gnt_idx;
    logic [1:0]      search_idx;
    logic            gnt_any;
    logic [NREQ-1:0] gnt;

    // Search from the pointer upward; the pointer lands just past the winner,
    // so any requester held valid waits at most three cycles.
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = p_q;
        search_idx = p_q;
        for (int i = 0; i < NREQ; i++) begin
            search_idx = p_q + 2'(i);
            if (!gnt_any && bus.i_REQ_VALID[search_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = search_idx;
            end
        end
        if (!i_RSTN) begin
            gnt_any = 1'b0;
        end
        gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        p_d         = gnt_any ? (gnt_idx + 2'd1) : p_q;
        rsp_valid_d = (gnt_any && !bus.i_REQ_WE[gnt_idx]) ? gnt : '0;
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            p_q         <= 2'd0;
            rsp_valid_q <= '0;
        end else begin
            p_q         <= p_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.o_REQ_READY = gnt;
    assign bus.o_MEM_EN    = gnt_any;
    assign bus.o_MEM_WE    = gnt_any & bus.i_REQ_WE[gnt_idx];
    assign bus.o_MEM_ADDR  = gnt_any ? req_addr[gnt_idx]  : '0;
    assign bus.o_MEM_WDATA = gnt_any ? req_wdata[gnt_idx] : '0;

    // Memory read data is only forwarded in the cycle its response is owed.
    assign bus.o_RSP_VALID = rsp_valid_q;
    assign bus.o_RSP_RDATA = (|rsp_valid_q) ? bus.i_MEM_RDATA : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, round-robin reference model and a
// response scoreboard checked every cycle, plus directed expectations per scenario.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.data_width(DW), .addr_width(AW), .NREQ(4)) ifc ();

    dmem_arbiter #(.data_width(DW), .addr_width(AW), .NREQ(4)) dut (
        .i_CLK  (clk),
        .i_RSTN (rst_n),
        .bus    (ifc)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ifc.o_MEM_EN) begin
            if (ifc.o_MEM_WE) mem[ifc.o_MEM_ADDR] <= ifc.o_MEM_WDATA;
            else              ifc.i_MEM_RDATA     <= mem[ifc.o_MEM_ADDR];
        end
    end

    typedef struct {
        logic [3:0]    id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0]    mp;
    int            wait_cnt [4];
    logic [3:0]    obs_gnt;
    logic          obs_we;
    logic [3:0]    obs_rsp_v;
    logic [DW-1:0] obs_rsp_d;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic set_req(input int j, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifc.i_REQ_VALID[j]          = v;
        ifc.i_REQ_WE[j]             = we;
        ifc.i_REQ_ADDR[j*AW +: AW]  = a;
        ifc.i_REQ_WDATA[j*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        for (int j = 0; j < 4; j++) set_req(j, 1'b0, 1'b0, '0, '0);
    endtask

    // Called just after a falling edge with inputs already driven; checks the
    // cycle, updates the model and returns at the next falling edge.
    task automatic cyc();
        logic [3:0]    exp_g;
        logic          found;
        int            k;
        int            jj;
        logic [AW-1:0] ea;
        rsp_t          e;
        #1;
        found = 1'b0;
        k     = 0;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                jj = (int'(mp) + i) % 4;
                if (!found && ifc.i_REQ_VALID[jj]) begin
                    found = 1'b1;
                    k     = jj;
                end
            end
        end
        exp_g = found ? (4'b0001 << k) : 4'b0000;
        ea    = ifc.i_REQ_ADDR[k*AW +: AW];
        check_val("ready",  32'(ifc.o_REQ_READY), 32'(exp_g));
        check_val("mem_en", 32'(ifc.o_MEM_EN),    32'(found));
        check_val("mem_we", 32'(ifc.o_MEM_WE),    32'(found & ifc.i_REQ_WE[k]));
        check_val("mem_addr", 32'(ifc.o_MEM_ADDR), found ? 32'(ea) : 32'd0);
        check_val("mem_wdata", ifc.o_MEM_WDATA, found ? ifc.i_REQ_WDATA[k*DW +: DW] : 32'd0);

        if (!rst_n) rsp_q.delete();
        if (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            check_val("rsp_valid", 32'(ifc.o_RSP_VALID), 32'(e.id));
            check_val("rsp_rdata", ifc.o_RSP_RDATA, e.data);
        end else begin
            check_val("rsp_idle_valid", 32'(ifc.o_RSP_VALID), 32'd0);
            check_val("rsp_idle_rdata", ifc.o_RSP_RDATA, 32'd0);
        end
        if (found && !ifc.i_REQ_WE[k]) begin
            e.id   = exp_g;
            e.data = mem[ea];
            rsp_q.push_back(e);
        end

        for (int j = 0; j < 4; j++) begin
            if (!rst_n) wait_cnt[j] = 0;
            else if (ifc.o_REQ_READY[j]) begin
                check_val("wait_bound", 32'(wait_cnt[j] <= 3), 32'd1);
                wait_cnt[j] = 0;
            end else if (ifc.i_REQ_VALID[j]) wait_cnt[j]++;
        end

        obs_gnt   = ifc.o_REQ_READY;
        obs_we    = ifc.o_MEM_WE;
        obs_rsp_v = ifc.o_RSP_VALID;
        obs_rsp_d = ifc.o_RSP_RDATA;
        if (!rst_n)     mp = 2'd0;
        else if (found) mp = 2'(k + 1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) * 32'h9E37_79B9;
        mem[15'h0010] = 32'hDEAD_BEEF;
        ifc.i_MEM_RDATA = '0;
        for (int j = 0; j < 4; j++) wait_cnt[j] = 0;
        mp    = 2'd0;
        rst_n = 1'b0;
        clear_reqs();
        @(negedge clk);

        // Reset holds everything quiet even with all requesters asking.
        for (int j = 0; j < 4; j++) set_req(j, 1'b1, 1'b0, 15'(j + 1), '0);
        cyc();
        check_val("rst_ready", 32'(obs_gnt), 32'd0);
        check_val("rst_rsp", 32'(obs_rsp_v), 32'd0);
        clear_reqs();
        cyc();
        rst_n = 1'b1;

        // All four reading: grant order 0,1,2,3 then back to 0.
        for (int j = 0; j < 4; j++) set_req(j, 1'b1, 1'b0, 15'(16'h100 + j), '0);
        for (int c = 0; c < 5; c++) begin
            cyc();
            check_val("rr_order", 32'(obs_gnt), 32'(4'b0001 << (c % 4)));
        end
        clear_reqs();
        cyc();

        // Requester 2 reads the preloaded word.
        set_req(2, 1'b1, 1'b0, 15'h0010, '0);
        cyc();
        clear_reqs();
        cyc();
        check_val("r2_rsp_valid", 32'(obs_rsp_v), 32'h4);
        check_val("r2_rsp_data",  obs_rsp_d,      32'hDEAD_BEEF);

        // Requester 1 writes the top word and reads it back.
        set_req(1, 1'b1, 1'b1, 15'h7FFF, 32'h1234_5678);
        cyc();
        check_val("wr_we", 32'(obs_we), 32'd1);
        set_req(1, 1'b1, 1'b0, 15'h7FFF, '0);
        cyc();
        check_val("rd_we", 32'(obs_we), 32'd0);
        check_val("wr_no_rsp", 32'(obs_rsp_v), 32'd0);
        clear_reqs();
        cyc();
        check_val("rd_rsp_valid", 32'(obs_rsp_v), 32'h2);
        check_val("rd_rsp_data",  obs_rsp_d,      32'h1234_5678);

        // Requesters 0 and 3: pointer sits at 2, so 3 wins first, then alternate.
        set_req(0, 1'b1, 1'b0, 15'h0020, '0);
        set_req(3, 1'b1, 1'b0, 15'h0023, '0);
        for (int c = 0; c < 6; c++) begin
            cyc();
            check_val("alt_03", 32'(obs_gnt), (c % 2 == 0) ? 32'h8 : 32'h1);
        end
        clear_reqs();

        // Read accepted, then reset lands on the response cycle: it must vanish.
        set_req(0, 1'b1, 1'b0, 15'h0030, '0);
        cyc();
        check_val("pre_rst_gnt", 32'(obs_gnt), 32'h1);
        rst_n = 1'b0;
        cyc();
        check_val("rst_drop", 32'(obs_rsp_v), 32'd0);
        rst_n = 1'b1;
        clear_reqs();
        cyc();
        check_val("post_rst_rsp", 32'(obs_rsp_v), 32'd0);
        for (int j = 0; j < 4; j++) set_req(j, 1'b1, 1'b0, 15'(16'h200 + j), '0);
        cyc();
        check_val("post_rst_p0", 32'(obs_gnt), 32'h1);
        clear_reqs();

        // Five idle cycles leave the pointer at 1.
        for (int c = 0; c < 5; c++) begin
            cyc();
            check_val("idle_en", 32'(obs_gnt), 32'd0);
        end
        for (int j = 0; j < 4; j++) set_req(j, 1'b1, 1'b0, 15'(16'h300 + j), '0);
        cyc();
        check_val("idle_p_hold", 32'(obs_gnt), 32'h2);
        clear_reqs();

        // Random traffic; requesters hold their request until accepted.
        for (int c = 0; c < 300; c++) begin
            for (int j = 0; j < 4; j++) begin
                if (obs_gnt[j] || !ifc.i_REQ_VALID[j])
                    set_req(j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            15'($urandom_range(0, 31)), $urandom);
            end
            cyc();
        end
        clear_reqs();
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
